// File: rtl/muldiv_sequencer.sv
// Purpose: iterative RV32M multiply/divide unit (shift-add multiply, restoring divide).
// Latency: 33 cycles start-to-done (32 iterations); 1 cycle for divide-by-zero / signed overflow.
// Backpressure: stall holds the pipeline while a request is accepted or in flight; start ignored unless IDLE.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start, funct3     request and RV32M operation select (sampled only in IDLE)
//   rs1, rs2          operand A / dividend, operand B / divisor
//   flush             aborts an operation in CALC; blocks acceptance in IDLE
//   busy, done        busy while iterating; done is a one-cycle result-valid pulse
//   result            final result, held until the next accepted start
//   stall             combinational pipeline hold request
module muldiv_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            stall
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t            state;
  logic [2:0]        op_q;
  logic              neg_q;      // final result must be two's-complement negated
  logic [XLEN-1:0]   mcand_q;    // multiplicand magnitude, or divisor magnitude
  logic [2*XLEN-1:0] prod_q;     // {partial, multiplier} or {remainder, dividend/quotient}
  logic [4:0]        cnt_q;

  // ---------------- request decode (IDLE) ----------------
  logic            is_div;
  logic            a_sgn;
  logic            b_sgn;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic            div_zero;
  logic            div_ovf;
  logic            fast;
  logic [XLEN-1:0] fast_res;
  logic            neg_init;

  always_comb begin
    is_div   = funct3[2];
    // operand A is signed for MULH, MULHSU, DIV, REM; operand B for MULH, DIV, REM
    a_sgn    = rs1[XLEN-1] & ((funct3 == 3'b001) | (funct3 == 3'b010) |
                              (funct3 == 3'b100) | (funct3 == 3'b110));
    b_sgn    = rs2[XLEN-1] & ((funct3 == 3'b001) | (funct3 == 3'b100) |
                              (funct3 == 3'b110));
    a_mag    = a_sgn ? (~rs1 + 1'b1) : rs1;
    b_mag    = b_sgn ? (~rs2 + 1'b1) : rs2;
    div_zero = is_div & (rs2 == '0);
    div_ovf  = is_div & ~funct3[0] & (rs1 == MIN_NEG) & (rs2 == '1);
    fast     = div_zero | div_ovf;
    // remainder follows the dividend sign; product and quotient follow the sign XOR
    neg_init = (funct3[2] & funct3[1]) ? a_sgn : (a_sgn ^ b_sgn);
    if (div_zero) fast_res = funct3[1] ? rs1 : '1;
    else          fast_res = funct3[1] ? '0  : MIN_NEG;
  end

  // ---------------- one iteration step (CALC) ----------------
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_trial;
  logic [2*XLEN-1:0] prod_nx;
  logic [2*XLEN-1:0] mul_p;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   fin_res;

  always_comb begin
    // shift-add: add multiplicand into the upper half when the multiplier LSB is set, shift right
    mul_sum   = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    // restoring: try subtracting the divisor from the remainder shifted left by one
    div_trial = prod_q[2*XLEN-1:XLEN-1] - {1'b0, mcand_q};
    if (op_q[2]) begin
      if (div_trial[XLEN]) prod_nx = {prod_q[2*XLEN-2:0], 1'b0};
      else                 prod_nx = {div_trial[XLEN-1:0], prod_q[XLEN-2:0], 1'b1};
    end else begin
      prod_nx = {mul_sum, prod_q[XLEN-1:1]};
    end

    mul_p = neg_q ? (~prod_nx + 1'b1) : prod_nx;
    quo   = neg_q ? (~prod_nx[XLEN-1:0] + 1'b1) : prod_nx[XLEN-1:0];
    rem   = neg_q ? (~prod_nx[2*XLEN-1:XLEN] + 1'b1) : prod_nx[2*XLEN-1:XLEN];

    if (!op_q[2])      fin_res = (op_q == 3'b000) ? mul_p[XLEN-1:0] : mul_p[2*XLEN-1:XLEN];
    else if (!op_q[1]) fin_res = quo;
    else               fin_res = rem;
  end

  assign stall = (start & (state == IDLE) & ~flush) | (state == CALC);

  // ---------------- sequencer ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      op_q    <= '0;
      neg_q   <= 1'b0;
      mcand_q <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start && !flush) begin
            op_q    <= funct3;
            neg_q   <= neg_init;
            cnt_q   <= '0;
            mcand_q <= is_div ? b_mag : a_mag;
            prod_q  <= {{XLEN{1'b0}}, (is_div ? a_mag : b_mag)};
            if (fast) begin
              state  <= DONE;
              done   <= 1'b1;
              result <= fast_res;
            end else begin
              state <= CALC;
              busy  <= 1'b1;
            end
          end
        end
        CALC: begin
          if (flush) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            prod_q <= prod_nx;
            cnt_q  <= cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
              state  <= DONE;
              busy   <= 1'b0;
              done   <= 1'b1;
              result <= fin_res;
            end
          end
        end
        DONE: begin
          // flush here does not cancel the pulse already presented
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
